// File: rtl/nibble_mux_sequencer_pkg.sv
// nibble_mux_sequencer shared types
// State encoding, counter width and mux select constants.
package nibble_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEL_A = 2'd1;
  localparam logic [1:0] ST_SEL_B = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam int CNT_W = 4;

  localparam logic SEL_A_INPUT = 1'b0;
  localparam logic SEL_B_INPUT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SEL_A = ST_SEL_A,
    SEL_B = ST_SEL_B,
    OUT   = ST_OUT
  } state_t;

endpackage

// File: rtl/nibble_mux_sequencer_if.sv
// nibble_mux_sequencer word output handshake
// Assembled byte offered with valid, accepted on valid & ready.
interface nibble_mux_sequencer_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/nibble_mux_sequencer_settle.sv
// settle_counter: hold-off timer for mux select changes
// done is high once SETTLE cycles have elapsed since clear.
module settle_counter #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic done
);

  import nibble_seq_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt;

  assign done = (cnt == LAST);

  // Count up from zero after clear; stop at LAST so it never wraps
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (!done) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nibble_mux_sequencer.sv
// nibble_mux_sequencer: reads a byte through a 74LS157 quad mux
// Samples A then B nibble after a settle delay, offers the word.
module nibble_mux_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] y,
  output logic       sel,
  output logic       strobe_n,
  output logic       busy,
  nibble_mux_sequencer_if.master bus
);

  import nibble_seq_pkg::*;

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("nibble_mux_sequencer: SETTLE must be 1..15");
  end

  state_t     st;
  state_t     nx;
  logic       done;
  logic       clear;
  logic       cap_a;
  logic       cap_b;
  logic [3:0] lo_stage;
  logic [7:0] data_q;
  logic       valid_d;

  settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .done  (done)
  );

  // Restart settle timing on every state entry; idle states keep it at zero
  assign clear = (nx != st) || (st == IDLE) || (st == OUT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
    end else begin
      st <= nx;
    end
  end

  // Next-state and capture strobes; abort beats a pending capture
  always_comb begin
    nx    = st;
    cap_a = 1'b0;
    cap_b = 1'b0;
    unique case (st)
      IDLE: begin
        if (start) nx = SEL_A;
      end
      SEL_A: begin
        if (abort) begin
          nx = IDLE;
        end else if (done) begin
          cap_a = 1'b1;
          nx    = SEL_B;
        end
      end
      SEL_B: begin
        if (abort) begin
          nx = IDLE;
        end else if (done) begin
          cap_b = 1'b1;
          nx    = OUT;
        end
      end
      OUT: begin
        if (bus.ready) nx = IDLE;
      end
      default: nx = IDLE;
    endcase
  end

  // Mux control and status decoded from state only
  always_comb begin
    sel      = SEL_A_INPUT;
    strobe_n = 1'b1;
    busy     = 1'b1;
    valid_d  = 1'b0;
    unique case (st)
      IDLE: begin
        busy = 1'b0;
      end
      SEL_A: begin
        strobe_n = 1'b0;
      end
      SEL_B: begin
        sel      = SEL_B_INPUT;
        strobe_n = 1'b0;
      end
      OUT: begin
        sel     = SEL_B_INPUT;
        valid_d = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Nibble capture; the word updates in one edge so it is never half-new
  always_ff @(posedge clk) begin
    if (reset) begin
      lo_stage <= 4'h0;
      data_q   <= 8'h00;
    end else begin
      if (cap_a) lo_stage <= y;
      if (cap_b) data_q <= {y, lo_stage};
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_d;

endmodule
